lfm_chirp_generator: RTL and testbench

LFM_CHIRP_GENERATOR -- requirements
Module: lfm_chirp_generator

---
 rtl/chirp_gen_pkg.sv | 15 +
 rtl/lfm_phase_accum.sv | 50 +++++
 rtl/lfm_chirp_generator.sv | 100 ++++++++++
 tb/tb_lfm_chirp_generator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/chirp_gen_pkg.sv
// chirp_gen_pkg: state encoding, chirp_parameters field offsets and default parameter values
package chirp_gen_pkg;
  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_READY  = 2'd1,
    ST_CHIRP  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;
  localparam int FIELD_W           = 32;
  localparam int CNT_MAX_LSB       = 0;
  localparam int COEF_LSB          = 32;
  localparam int OFFSET_LSB        = 64;
  localparam int DEF_WARMUP_CYCLES = 16;
  localparam int DEF_PHASE_OUT_W   = 16;
endpackage

// File: rtl/lfm_phase_accum.sv
// lfm_phase_accum: incremental frequency and phase accumulators for one chirp
// Ports: aclk/aresetn clock and async active-low reset; load_i latches offset_i/coef_i and
// zeroes phase; step_i advances one sample; clear_i zeroes everything; freq_o is the current
// frequency word, dac_phase_o the top PHASE_OUT_W bits of the 32-bit phase.
module lfm_phase_accum #(
  parameter int PHASE_OUT_W = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic                   clear_i,
  input  logic [31:0]            offset_i,
  input  logic [31:0]            coef_i,
  output logic [31:0]            freq_o,
  output logic [PHASE_OUT_W-1:0] dac_phase_o
);
  logic [31:0] freq_q, freq_d, phase_q, phase_d, coef_q, coef_d;
  always_comb begin
    freq_d  = freq_q;
    phase_d = phase_q;
    coef_d  = coef_q;
    if (clear_i) begin
      freq_d  = '0;
      phase_d = '0;
      coef_d  = '0;
    end else if (load_i) begin
      freq_d  = offset_i;
      phase_d = '0;
      coef_d  = coef_i;
    end else if (step_i) begin
      // phase integrates the word of the sample just emitted, then the word ramps
      freq_d  = freq_q + coef_q;
      phase_d = phase_q + freq_q;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      freq_q  <= '0;
      phase_q <= '0;
      coef_q  <= '0;
    end else begin
      freq_q  <= freq_d;
      phase_q <= phase_d;
      coef_q  <= coef_d;
    end
  end
  assign freq_o      = freq_q;
  assign dac_phase_o = phase_q[31 -: PHASE_OUT_W];
endmodule

// File: rtl/lfm_chirp_generator.sv
// lfm_chirp_generator: linear-FM chirp sequencer emitting frequency word and phase per sample
// Ports: aclk/aresetn clock and async active-low reset; chirp_parameters packs
// {reserved, freq_offset, tuning_coef, counter_max}; chirp_init/chirp_enable start and hold
// a chirp; chirp_ready/chirp_active/chirp_done report status; freq_word/dac_phase carry the
// sample, qualified by sample_valid and forced to zero otherwise.
module lfm_chirp_generator
  import chirp_gen_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int PHASE_OUT_W   = DEF_PHASE_OUT_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [127:0]           chirp_parameters,
  input  logic                   chirp_init,
  input  logic                   chirp_enable,
  output logic                   chirp_ready,
  output logic                   chirp_active,
  output logic                   chirp_done,
  output logic [31:0]            freq_word,
  output logic [PHASE_OUT_W-1:0] dac_phase,
  output logic                   sample_valid
);
  state_e state_q, state_d;
  logic [31:0] warm_q, warm_d, cmax_q, cmax_d, k_q, k_d, freq;
  logic [PHASE_OUT_W-1:0] phase;
  logic load, step, clear, unused_reserved;
  assign unused_reserved = ^chirp_parameters[127:96];
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cmax_d  = cmax_q;
    k_d     = k_q;
    load    = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (warm_q == 32'(WARMUP_CYCLES)) state_d = ST_READY;
        else warm_d = warm_q + 32'd1;
      end
      ST_READY: begin
        if (chirp_init && chirp_enable) begin
          state_d = ST_CHIRP;
          load    = 1'b1;
          cmax_d  = chirp_parameters[CNT_MAX_LSB +: FIELD_W];
          k_d     = '0;
        end
      end
      ST_CHIRP: begin
        // losing enable aborts silently and wins over reaching the last sample
        if (!chirp_enable) begin
          state_d = ST_READY;
          clear   = 1'b1;
        end else if (k_q == cmax_q) begin
          state_d = ST_DONE;
          clear   = 1'b1;
        end else begin
          step = 1'b1;
          k_d  = k_q + 32'd1;
        end
      end
      ST_DONE: state_d = ST_READY;
      default: begin
        state_d = ST_WARMUP;
        warm_d  = '0;
      end
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_WARMUP;
      warm_q  <= '0;
      cmax_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cmax_q  <= cmax_d;
      k_q     <= k_d;
    end
  end
  lfm_phase_accum #(.PHASE_OUT_W(PHASE_OUT_W)) u_accum (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .load_i      (load),
    .step_i      (step),
    .clear_i     (clear),
    .offset_i    (chirp_parameters[OFFSET_LSB +: FIELD_W]),
    .coef_i      (chirp_parameters[COEF_LSB +: FIELD_W]),
    .freq_o      (freq),
    .dac_phase_o (phase)
  );
  assign chirp_ready  = state_q == ST_READY;
  assign chirp_active = state_q == ST_CHIRP;
  assign chirp_done   = state_q == ST_DONE;
  assign sample_valid = chirp_active;
  assign freq_word    = chirp_active ? freq : '0;
  assign dac_phase    = chirp_active ? phase : '0;
endmodule

// File: tb/tb_lfm_chirp_generator.sv
// tb_lfm_chirp_generator: directed literal checks plus randomized traffic against a closed-form chirp model
module tb_lfm_chirp_generator;
  localparam int W = 32;
  localparam int M_WARM = 0, M_READY = 1, M_CHIRP = 2, M_DONE = 3;
  logic aclk = 1'b0, aresetn = 1'b0, chirp_init = 1'b0, chirp_enable = 1'b0;
  logic [127:0] chirp_parameters = '0;
  logic chirp_ready, chirp_active, chirp_done, sample_valid;
  logic [31:0] freq_word;
  logic [W-1:0] dac_phase;
  int total = 0, bad = 0;
  int m_mode = M_WARM, m_warm = 0;
  logic [31:0] m_off = '0, m_coef = '0, m_cmax = '0, m_k = '0;

  lfm_chirp_generator #(.WARMUP_CYCLES(16), .PHASE_OUT_W(W)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .chirp_parameters (chirp_parameters),
    .chirp_init       (chirp_init),
    .chirp_enable     (chirp_enable),
    .chirp_ready      (chirp_ready),
    .chirp_active     (chirp_active),
    .chirp_done       (chirp_done),
    .freq_word        (freq_word),
    .dac_phase        (dac_phase),
    .sample_valid     (sample_valid)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Chirp behaviour as counts: warmup cycles, sample index k, latched parameters.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_mode = M_WARM; m_warm = 0; m_k = '0; m_off = '0; m_coef = '0; m_cmax = '0;
    end else if (m_mode == M_WARM) begin
      if (m_warm == 16) m_mode = M_READY;
      else m_warm++;
    end else if (m_mode == M_READY) begin
      if (chirp_init && chirp_enable) begin
        m_mode = M_CHIRP; m_k = '0;
        m_off = chirp_parameters[95:64]; m_coef = chirp_parameters[63:32]; m_cmax = chirp_parameters[31:0];
      end
    end else if (m_mode == M_CHIRP) begin
      if (!chirp_enable) m_mode = M_READY;
      else if (m_k == m_cmax) m_mode = M_DONE;
      else m_k = m_k + 1;
    end else m_mode = M_READY;
  end

  function automatic logic [31:0] exp_fw();
    return (m_mode == M_CHIRP) ? m_off + m_k * m_coef : 32'h0;
  endfunction

  // phase(k) = k*offset + coef*k*(k-1)/2, the sum of all earlier frequency words
  function automatic logic [31:0] exp_ph();
    logic [63:0] kk, p;
    kk = 64'(m_k);
    p = kk * 64'(m_off) + 64'(m_coef) * ((kk * (kk - 64'd1)) >> 1);
    return (m_mode == M_CHIRP) ? p[31:0] : 32'h0;
  endfunction

  always @(negedge aclk) begin
    chk("m_ready", 32'(chirp_ready), 32'(m_mode == M_READY));
    chk("m_active", 32'(chirp_active), 32'(m_mode == M_CHIRP));
    chk("m_valid", 32'(sample_valid), 32'(m_mode == M_CHIRP));
    chk("m_done", 32'(chirp_done), 32'(m_mode == M_DONE));
    chk("m_freq", freq_word, exp_fw());
    chk("m_phase", dac_phase, exp_ph());
  end

  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, 32'(chirp_ready), 0);
    chk({tag, "_active"}, 32'(chirp_active), 0);
    chk({tag, "_done"}, 32'(chirp_done), 0);
    chk({tag, "_valid"}, 32'(sample_valid), 0);
    chk({tag, "_freq"}, freq_word, 0);
    chk({tag, "_phase"}, dac_phase, 0);
  endtask

  task automatic warmup_check();
    for (int i = 1; i <= 17; i++) begin
      @(negedge aclk);
      chk("warm_ready", 32'(chirp_ready), 32'(i == 17));
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!chirp_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!chirp_ready) chk("ready_timeout", 32'(chirp_ready), 1);
  endtask

  task automatic start(input logic [31:0] off, input logic [31:0] coef, input logic [31:0] cmax);
    wait_ready();
    chirp_parameters = {32'h0, off, coef, cmax};
    chirp_init = 1'b1;
    chirp_enable = 1'b1;
    @(negedge aclk);
    chirp_init = 1'b0;
  endtask

  initial begin
    logic [31:0] fa [4] = '{32'h600, 32'h601, 32'h602, 32'h603};
    logic [31:0] pa [4] = '{32'h0, 32'h600, 32'hC01, 32'h1203};
    logic [31:0] fw [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    #3 all_zero("rst");
    @(negedge aclk);
    aresetn = 1'b1;
    warmup_check();
    start(32'h600, 32'h1, 32'd3);
    for (int k = 0; k < 4; k++) begin
      chk("base_freq", freq_word, fa[k]);
      chk("base_phase", dac_phase, pa[k]);
      chk("base_ready", 32'(chirp_ready), 0);
      @(negedge aclk);
    end
    chk("base_done", 32'(chirp_done), 1);
    chk("base_active_off", 32'(chirp_active), 0);
    @(negedge aclk);
    chk("base_done_once", 32'(chirp_done), 0);
    chk("base_ready_back", 32'(chirp_ready), 1);
    start(32'h1234, 32'h7, 32'd0);
    chk("one_freq", freq_word, 32'h1234);
    @(negedge aclk);
    chk("one_done", 32'(chirp_done), 1);
    chk("one_active", 32'(chirp_active), 0);
    start(32'hFFFFFFFE, 32'h1, 32'd3);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_freq", freq_word, fw[k]);
      @(negedge aclk);
    end
    chk("wrap_done", 32'(chirp_done), 1);
    wait_ready();
    chirp_init = 1'b1;
    chirp_enable = 1'b0;
    @(negedge aclk);
    chirp_init = 1'b0;
    chk("noen_active", 32'(chirp_active), 0);
    chk("noen_ready", 32'(chirp_ready), 1);
    start(32'h100, 32'h2, 32'd3);
    chirp_init = 1'b1;
    chirp_parameters = {32'h0, 32'hDEAD0000, 32'h55, 32'd40};
    for (int k = 0; k < 4; k++) begin
      chk("hold_freq", freq_word, 32'h100 + 32'(2 * k));
      @(negedge aclk);
      chirp_init = 1'b0;
    end
    chk("hold_done", 32'(chirp_done), 1);
    start(32'h0, 32'h1, 32'd10);
    @(negedge aclk);
    @(negedge aclk);
    chk("abort_s2", freq_word, 32'h2);
    chirp_enable = 1'b0;
    @(negedge aclk);
    chk("abort_active", 32'(chirp_active), 0);
    chk("abort_done", 32'(chirp_done), 0);
    chk("abort_ready", 32'(chirp_ready), 1);
    @(negedge aclk);
    chk("abort_nodone", 32'(chirp_done), 0);
    start(32'h5, 32'h5, 32'd10);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 all_zero("midrst");
    @(negedge aclk);
    aresetn = 1'b1;
    warmup_check();
    for (int c = 0; c < 4000; c++) begin
      @(negedge aclk);
      chirp_enable = ($urandom % 12) != 0;
      chirp_init = ($urandom % 3) == 0;
      chirp_parameters = {$urandom, $urandom, (($urandom % 4) != 0) ? 32'($urandom % 5) : $urandom, 32'($urandom % 9)};
      if ($urandom % 500 == 0) begin
        #2 aresetn = 1'b0;
        #2 aresetn = 1'b1;
      end
    end
    @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
